// File: rtl/secuenciador_slots_pkg.sv
// Shared definitions for the four-slot pneumatic step sequencer.
package secuenciador_slots_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } estado_t;

   localparam logic [1:0] SENS_A0 = 2'd0;
   localparam logic [1:0] SENS_A1 = 2'd1;
   localparam logic [1:0] SENS_B0 = 2'd2;
   localparam logic [1:0] SENS_B1 = 2'd3;

   // Sensor index that ends step 'paso', packed two bits per step.
   function automatic logic [1:0] sel_paso(input logic [7:0] sel, input logic [1:0] paso);
      return sel[{paso, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/secuenciador_slots_filtro.sv
// Input conditioning: 2-flop synchronizer followed by a consecutive-sample debouncer.
module filtro_entrada #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic             sync_p0;
   logic             sync_p1;
   logic [DEB_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         dout    <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         // Any sample agreeing with the current output restarts the run.
         if (sync_p1 != dout) begin
            if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
               dout <= sync_p1;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/secuenciador_slots.sv
// Four-slot cylinder step sequencer: filtered start/sensors, per-step watchdog,
// emergency stop and saturating completed-cycle counter.
module secuenciador_slots
   import secuenciador_slots_pkg::*;
#(
   parameter int DEB_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [3:0]       SENSOR,
   input  logic             STOP,
   input  logic             CLR_FAULT,
   input  logic [1:0]       START_SEL,
   input  logic [7:0]       STEP_SEL,
   output logic [3:0]       Q,
   output logic [1:0]       STEP,
   output logic             BUSY,
   output logic             DONE,
   output logic             FAULT,
   output logic [CNT_W-1:0] CYCLE_CNT
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             start_f;
   logic             start_prev;
   logic [3:0]       sens_f;
   logic             stop_p0;
   logic             stop_p1;
   estado_t          estado;
   logic [TMR_W-1:0] timer;
   logic [7:0]       sel_lat;
   logic             start_rise;
   logic             confirma;
   logic             vencido;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   filtro_entrada #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_start (
      .clk  (CLK),
      .rst  (RESET),
      .din  (START),
      .dout (start_f)
   );

   for (genvar i = 0; i < 4; i++) begin : g_sens
      filtro_entrada #(.DEB_CYCLES(DEB_CYCLES)) u_filtro_sens (
         .clk  (CLK),
         .rst  (RESET),
         .din  (SENSOR[i]),
         .dout (sens_f[i])
      );
   end

   assign start_rise = start_f & ~start_prev;
   assign confirma   = sens_f[sel_paso(sel_lat, STEP)];
   assign vencido    = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

   // STOP is only synchronized so the emergency path stays fast.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stop_p0    <= 1'b0;
         stop_p1    <= 1'b0;
         start_prev <= 1'b0;
      end else begin
         stop_p0    <= STOP;
         stop_p1    <= stop_p0;
         start_prev <= start_f;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         estado    <= ST_IDLE;
         timer     <= '0;
         sel_lat   <= '0;
         Q         <= '0;
         STEP      <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FAULT     <= 1'b0;
         CYCLE_CNT <= '0;
      end else begin
         DONE <= 1'b0;
         if (stop_p1) begin
            estado <= ST_FAULT;
            Q      <= '0;
            BUSY   <= 1'b0;
            FAULT  <= 1'b1;
         end else begin
            case (estado)
               ST_IDLE: begin
                  if (start_rise && sens_f[START_SEL]) begin
                     estado  <= ST_RUN;
                     STEP    <= 2'd0;
                     timer   <= '0;
                     sel_lat <= STEP_SEL;
                     Q       <= 4'b0001;
                     BUSY    <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // Confirmation is tested first so it wins over a coincident timeout.
                  if (confirma) begin
                     timer <= '0;
                     if (STEP == 2'd3) begin
                        estado    <= ST_IDLE;
                        Q         <= '0;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        CYCLE_CNT <= sat_inc(CYCLE_CNT);
                     end else begin
                        STEP <= STEP + 2'd1;
                        Q    <= Q << 1;
                     end
                  end else if (vencido) begin
                     estado <= ST_FAULT;
                     Q      <= '0;
                     BUSY   <= 1'b0;
                     FAULT  <= 1'b1;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               ST_FAULT: begin
                  if (CLR_FAULT) begin
                     estado <= ST_IDLE;
                     FAULT  <= 1'b0;
                  end
               end
               default: begin
                  estado <= ST_IDLE;
                  Q      <= '0;
                  BUSY   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_secuenciador_slots.sv
// Randomized and directed bench for secuenciador_slots against a sample-history reference model.
module tb_secuenciador_slots;

   localparam int DEB = 4;
   localparam int TMO = 50;
   localparam logic [7:0] NOMINAL = 8'b00_10_01_11;

   logic        clk = 1'b0;
   logic        rst, start, stop, clr;
   logic [3:0]  sensor;
   logic [1:0]  start_sel;
   logic [7:0]  step_sel;
   logic [3:0]  q, q_s;
   logic [1:0]  step, step_s;
   logic        busy, busy_s, done, done_s, fault, fault_s;
   logic [15:0] cnt;
   logic [1:0]  cnt_s;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int n_done_s = 0;

   // Reference model: raw sample history per input (0=start, 1..4=sensors, 5=stop).
   logic [4:0] hist [6];
   logic [4:0] filt;
   logic       m_prev;
   bit         m_run, m_fault, m_done;
   int         m_step, m_tmr, m_ncyc;
   logic [7:0] m_sel;

   always #5 clk = ~clk;

   secuenciador_slots #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
      .CLK(clk), .RESET(rst), .START(start), .SENSOR(sensor), .STOP(stop),
      .CLR_FAULT(clr), .START_SEL(start_sel), .STEP_SEL(step_sel),
      .Q(q), .STEP(step), .BUSY(busy), .DONE(done), .FAULT(fault), .CYCLE_CNT(cnt)
   );

   secuenciador_slots #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_W(2)) dut_sat (
      .CLK(clk), .RESET(rst), .START(start), .SENSOR(sensor), .STOP(stop),
      .CLR_FAULT(clr), .START_SEL(start_sel), .STEP_SEL(step_sel),
      .Q(q_s), .STEP(step_s), .BUSY(busy_s), .DONE(done_s), .FAULT(fault_s), .CYCLE_CNT(cnt_s)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) hist[i] = '0;
      filt    = '0;
      m_prev  = 1'b0;
      m_run   = 0;
      m_fault = 0;
      m_done  = 0;
      m_step  = 0;
      m_tmr   = 0;
      m_ncyc  = 0;
      m_sel   = '0;
   endtask

   task automatic model_edge();
      logic [5:0] raw;
      bit         rise;
      int         idx;
      raw  = {stop, sensor, start};
      rise = filt[0] && !m_prev;
      m_done = 0;
      // hist[i][1] is what the design sees as the synchronized value at this edge.
      if (hist[5][1]) begin
         m_run   = 0;
         m_fault = 1;
      end else if (m_run) begin
         idx = int'(m_sel[2*m_step +: 2]);
         if (filt[1+idx]) begin
            m_tmr = 0;
            if (m_step == 3) begin
               m_run  = 0;
               m_done = 1;
               m_ncyc++;
            end else begin
               m_step++;
            end
         end else if (m_tmr == TMO - 1) begin
            m_run   = 0;
            m_fault = 1;
         end else begin
            m_tmr++;
         end
      end else if (m_fault) begin
         if (clr) m_fault = 0;
      end else if (rise && filt[1+int'(start_sel)]) begin
         m_run  = 1;
         m_step = 0;
         m_tmr  = 0;
         m_sel  = step_sel;
      end
      m_prev = filt[0];
      for (int i = 0; i < 5; i++) begin
         if (hist[i][1] != filt[i] && hist[i][2] != filt[i] &&
             hist[i][3] != filt[i] && hist[i][4] != filt[i])
            filt[i] = hist[i][1];
      end
      for (int i = 0; i < 6; i++) hist[i] = {hist[i][3:0], raw[i]};
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      if (done) n_done++;
      if (done_s) n_done_s++;
      check_val("q", 32'(q), m_run ? (32'd1 << m_step) : 32'd0);
      check_val("step", 32'(step), m_step);
      check_val("busy", 32'(busy), 32'(m_run));
      check_val("done", 32'(done), 32'(m_done));
      check_val("fault", 32'(fault), 32'(m_fault));
      check_val("cnt", 32'(cnt), (m_ncyc > 65535) ? 65535 : m_ncyc);
      check_val("cnt_sat", 32'(cnt_s), (m_ncyc > 3) ? 3 : m_ncyc);
      check_val("done_sat", 32'(done_s), 32'(m_done));
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_busy(input bit want, input int lim, input string tag);
      int k = 0;
      while (busy !== want && k < lim) begin
         tick();
         k++;
      end
      check_val(tag, 32'(busy), 32'(want));
   endtask

   task automatic wait_step(input int target, input int lim, input string tag);
      int k = 0;
      while (step != 2'(target) && busy && k < lim) begin
         tick();
         k++;
      end
      check_val(tag, 32'(step), target);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_q", 32'(q), 0);
      check_val("rst_step", 32'(step), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_fault", 32'(fault), 0);
      check_val("rst_cnt", 32'(cnt), 0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic run_cycle(input logic [1:0] ss, input logic [7:0] sel, input bit hold);
      int w;
      start_sel = ss;
      step_sel  = sel;
      sensor    = 4'b0001 << ss;
      start     = 1'b0;
      ticks(8);
      start = 1'b1;
      wait_busy(1'b1, 20, "arranque");
      if (!hold) start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sensor = '0;
         ticks(19);
         sensor = 4'b0001 << sel[2*k +: 2];
         w = 0;
         while (busy && step == 2'(k) && w < 30) begin
            tick();
            w++;
         end
         if (k < 3) check_val("avance", 32'(step), k + 1);
         else       check_val("fin", 32'(busy), 0);
      end
   endtask

   initial begin
      int k, d0;
      rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
      sensor = '0; start_sel = '0; step_sel = '0;
      model_reset();
      ticks(2);
      rst = 1'b0;
      ticks(2);

      // Nominal cycle
      run_cycle(2'd0, NOMINAL, 1'b0);
      check_val("nom_done_pulses", n_done, 1);
      check_val("nom_cnt", 32'(cnt), 1);

      // Step watchdog
      sensor = 4'b0001;
      ticks(8);
      start = 1'b1;
      wait_busy(1'b1, 20, "to_arranque");
      start = 1'b0;
      k = 0;
      while (!fault && k < 100) begin
         tick();
         k++;
      end
      check_val("to_latencia", k, TMO);
      check_val("to_q", 32'(q), 0);
      check_val("to_step", 32'(step), 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_val("to_clr", 32'(fault), 0);

      // Emergency stop in step 2
      sensor = 4'b0001;
      ticks(8);
      start = 1'b1;
      wait_busy(1'b1, 20, "stop_arranque");
      start = 1'b0;
      sensor = 4'b1000;
      wait_step(1, 30, "stop_paso1");
      sensor = 4'b0010;
      wait_step(2, 30, "stop_paso2");
      sensor = '0;
      ticks(3);
      stop = 1'b1;
      k = 0;
      while (!fault && k < 10) begin
         tick();
         k++;
      end
      check_val("stop_latencia", k, 3);
      check_val("stop_q", 32'(q), 0);
      clr = 1'b1;
      ticks(5);
      check_val("stop_clr_ignorado", 32'(fault), 1);
      stop = 1'b0;
      ticks(4);
      check_val("stop_clr", 32'(fault), 0);
      clr = 1'b0;

      // Debounce and start interlock
      sensor = 4'b0001;
      ticks(8);
      start = 1'b1;
      ticks(3);
      start = 1'b0;
      ticks(12);
      check_val("glitch_start", 32'(busy), 0);
      sensor = '0;
      ticks(8);
      start = 1'b1;
      ticks(12);
      check_val("sin_home", 32'(busy), 0);
      start = 1'b0;
      ticks(8);
      run_cycle(2'd0, NOMINAL, 1'b1);
      ticks(15);
      check_val("start_mantenido", 32'(busy), 0);
      start = 1'b0;
      ticks(8);
      start = 1'b1;
      wait_busy(1'b1, 20, "segunda_pulsacion");
      start = 1'b0;

      // Reset in the middle of step 1
      sensor = 4'b1000;
      wait_step(1, 30, "rst_paso1");
      async_reset();
      run_cycle(2'd0, NOMINAL, 1'b0);
      check_val("post_rst_cnt", 32'(cnt), 1);

      // Counter saturation
      d0 = n_done_s;
      repeat (5) run_cycle(2'd0, NOMINAL, 1'b0);
      check_val("sat_pulsos", n_done_s - d0, 5);
      check_val("sat_cnt", 32'(cnt_s), 3);
      check_val("sat_cnt16", 32'(cnt), 6);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(15) == 0) sensor[$urandom_range(3)] = ~sensor[$urandom_range(3)];
         if ($urandom_range(24) == 0) start = ~start;
         if (stop) stop = ($urandom_range(9) != 0);
         else      stop = ($urandom_range(299) == 0);
         clr = ($urandom_range(7) == 0);
         if ($urandom_range(99) == 0) step_sel = 8'($urandom);
         if ($urandom_range(199) == 0) start_sel = 2'($urandom);
         if ($urandom_range(999) == 0) async_reset();
         else tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
